// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: start/pause/clear/lap handling on top of an
// external BCD min:sec counter chain, with a terminal count of LIMIT_MIN:59.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | stopped, count cleared or awaiting first start
// ST_RUN   | counting on tick
// ST_PAUSE | count frozen, resumable
// ST_DONE  | terminal count reached, only clear is accepted
module stopwatch_ctrl #(
    parameter int unsigned LIMIT_MIN = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btnStart,
    input  logic       btnLap,
    input  logic       btnClear,
    input  logic [3:0] secUnits,
    input  logic [2:0] secTens,
    input  logic [3:0] minUnits,
    input  logic [2:0] minTens,
    output logic       cntEn,
    output logic       cntClr,
    output logic [3:0] dispSecUnits,
    output logic [2:0] dispSecTens,
    output logic [3:0] dispMinUnits,
    output logic [2:0] dispMinTens,
    output logic       lapActive,
    output logic [1:0] state,
    output logic       done
);

    localparam logic [2:0] LIM_TENS  = 3'(LIMIT_MIN / 10);
    localparam logic [3:0] LIM_UNITS = 4'(LIMIT_MIN % 10);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t      cur_state;
    state_t      nxt_state;
    logic        start_q;
    logic        lap_btn_q;
    logic        clr_q;
    logic        start_edge;
    logic        lap_edge;
    logic        clr_edge;
    logic        at_limit;
    logic        clr_accept;
    logic        lap_toggle;
    logic [13:0] live_digits;
    logic [13:0] lap_q;

    assign start_edge  = btnStart & ~start_q;
    assign lap_edge    = btnLap   & ~lap_btn_q;
    assign clr_edge    = btnClear & ~clr_q;
    assign live_digits = {minTens, minUnits, secTens, secUnits};
    assign at_limit    = (minTens == LIM_TENS) && (minUnits == LIM_UNITS) &&
                         (secTens == 3'd5) && (secUnits == 4'd9);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q   <= 1'b0;
            lap_btn_q <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            start_q   <= btnStart;
            lap_btn_q <= btnLap;
            clr_q     <= btnClear;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Higher-priority events consume the cycle; losing edges are dropped.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            ST_IDLE: begin
                if (!clr_edge && start_edge) nxt_state = ST_RUN;
            end
            ST_RUN: begin
                if (at_limit)        nxt_state = ST_DONE;
                else if (start_edge) nxt_state = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (clr_edge)        nxt_state = ST_IDLE;
                else if (start_edge) nxt_state = ST_RUN;
            end
            ST_DONE: begin
                if (clr_edge) nxt_state = ST_IDLE;
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    always_comb begin
        clr_accept = 1'b0;
        lap_toggle = 1'b0;
        cntEn      = 1'b0;
        done       = 1'b0;
        case (cur_state)
            ST_IDLE: begin
                clr_accept = clr_edge;
            end
            ST_RUN: begin
                cntEn      = tick & ~at_limit;
                lap_toggle = lap_edge & ~at_limit & ~start_edge;
            end
            ST_PAUSE: begin
                clr_accept = clr_edge;
                lap_toggle = lap_edge & ~clr_edge & ~start_edge;
            end
            ST_DONE: begin
                clr_accept = clr_edge;
                done       = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cntClr    <= 1'b0;
            lapActive <= 1'b0;
            lap_q     <= '0;
        end else begin
            cntClr <= clr_accept;
            if (clr_accept) begin
                lapActive <= 1'b0;
            end else if (lap_toggle) begin
                lapActive <= ~lapActive;
                if (!lapActive) lap_q <= live_digits;
            end
        end
    end

    assign state = cur_state;
    assign {dispMinTens, dispMinUnits, dispSecTens, dispSecUnits} =
        lapActive ? lap_q : live_digits;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios then random button/tick/reset
// traffic, all checked each cycle against a seconds-based reference model.
module tb_stopwatch_ctrl;

    localparam int LIM  = 1;
    localparam int LMAX = LIM * 60 + 59;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        btnStart = 1'b0;
    logic        btnLap = 1'b0;
    logic        btnClear = 1'b0;
    logic [13:0] live_bcd = '0;
    logic [3:0]  secUnits, minUnits, dispSecUnits, dispMinUnits;
    logic [2:0]  secTens, minTens, dispSecTens, dispMinTens;
    logic        cntEn, cntClr, lapActive, done;
    logic [1:0]  state;
    logic [13:0] disp;

    assign {minTens, minUnits, secTens, secUnits} = live_bcd;
    assign disp = {dispMinTens, dispMinUnits, dispSecTens, dispSecUnits};

    stopwatch_ctrl #(.LIMIT_MIN(LIM)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .btnStart(btnStart), .btnLap(btnLap), .btnClear(btnClear),
        .secUnits(secUnits), .secTens(secTens), .minUnits(minUnits), .minTens(minTens),
        .cntEn(cntEn), .cntClr(cntClr),
        .dispSecUnits(dispSecUnits), .dispSecTens(dispSecTens),
        .dispMinUnits(dispMinUnits), .dispMinTens(dispMinTens),
        .lapActive(lapActive), .state(state), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // model: elapsed seconds plus mode 0=idle 1=run 2=pause 3=done
    int m_state, live, m_lap_val;
    bit m_lap, m_pulse, p_start, p_lap, p_clr;

    int n_en, n_clr, n_pause, n_run;
    logic [13:0] obs_disp;
    logic [1:0]  obs_state;
    logic        obs_lap, obs_done;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [13:0] to_bcd(input int s);
        int m, sc;
        m  = s / 60;
        sc = s % 60;
        return {3'(m / 10), 4'(m % 10), 3'(sc / 10), 4'(sc % 10)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_lap = 0; m_lap_val = 0; m_pulse = 0;
        p_start = 0; p_lap = 0; p_clr = 0;
    endtask

    task automatic model_step(input bit s, input bit l, input bit c, input bit t);
        bit se, le, ce, lim, en, clr_acc, tog;
        int nxt;
        se = s & !p_start; le = l & !p_lap; ce = c & !p_clr;
        lim = (live == LMAX);
        en  = (m_state == 1) && t && !lim;
        clr_acc = 0; tog = 0; nxt = m_state;
        if (m_state == 0) begin
            if (ce) clr_acc = 1;
            else if (se) nxt = 1;
        end else if (m_state == 1) begin
            if (lim) nxt = 3;
            else if (se) nxt = 2;
            else if (le) tog = 1;
        end else if (m_state == 2) begin
            if (ce) begin clr_acc = 1; nxt = 0; end
            else if (se) nxt = 1;
            else if (le) tog = 1;
        end else begin
            if (ce) begin clr_acc = 1; nxt = 0; end
        end
        if (tog) begin
            if (!m_lap) m_lap_val = live;
            m_lap = !m_lap;
        end
        if (clr_acc) m_lap = 0;
        // the external counter chain reacts to this cycle's clear/enable
        if (m_pulse) live = 0;
        else if (en) live++;
        m_pulse = clr_acc;
        m_state = nxt;
        p_start = s; p_lap = l; p_clr = c;
    endtask

    task automatic cyc(input bit s, input bit l, input bit c, input bit t, input bit r);
        @(negedge clk);
        btnStart = s; btnLap = l; btnClear = c; tick = t; reset = r;
        live_bcd = to_bcd(live);
        if (r) model_reset();
        #1;
        chk("state", 32'(state), 32'(m_state));
        chk("cnt_en", 32'(cntEn), 32'((m_state == 1) && t && (live != LMAX)));
        chk("cnt_clr", 32'(cntClr), 32'(m_pulse));
        chk("lap_active", 32'(lapActive), 32'(m_lap));
        chk("done", 32'(done), 32'(m_state == 3));
        chk("disp", 32'(disp), 32'(m_lap ? to_bcd(m_lap_val) : to_bcd(live)));
        obs_disp = disp; obs_state = state; obs_lap = lapActive; obs_done = done;
        if (cntEn) n_en++;
        if (cntClr) n_clr++;
        if (state == 2'b10) n_pause++;
        if (state == 2'b01) n_run++;
        @(posedge clk);
        if (!r) model_step(s, l, c, t);
    endtask

    initial begin
        bit s, l, c;
        live = 0;
        model_reset();
        repeat (3) cyc(0, 0, 0, 1, 1);

        // start, ten ticks
        cyc(1, 0, 0, 0, 0);
        n_en = 0;
        repeat (10) cyc(0, 0, 0, 1, 0);
        chk("s30_en_count", 32'(n_en), 32'd10);
        cyc(0, 0, 0, 0, 0);
        chk("s30_state", 32'(obs_state), 32'd1);
        chk("s30_disp", 32'(obs_disp), 32'(to_bcd(10)));

        // pause, ticks ignored, clear
        cyc(1, 0, 0, 0, 0);
        n_en = 0;
        repeat (5) cyc(0, 0, 0, 1, 0);
        chk("s31_en_count", 32'(n_en), 32'd0);
        chk("s31_state", 32'(obs_state), 32'd2);
        n_clr = 0;
        cyc(0, 0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        chk("s31_clr_count", 32'(n_clr), 32'd1);
        chk("s31_state_idle", 32'(obs_state), 32'd0);

        // lap capture at 01:23
        n_en = 0;
        cyc(1, 0, 0, 0, 0);
        repeat (83) cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("s32_lap_disp", 32'(obs_disp), 32'(to_bcd(83)));
        chk("s32_lap_on", 32'(obs_lap), 32'd1);
        chk("s32_en_total", 32'(n_en), 32'd86);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("s32_live_disp", 32'(obs_disp), 32'(to_bcd(86)));
        chk("s32_lap_off", 32'(obs_lap), 32'd0);

        // run into the 01:59 terminal count
        repeat (33) cyc(0, 0, 0, 1, 0);
        n_en = 0;
        repeat (10) cyc(0, 0, 0, 1, 0);
        chk("s33_en_at_limit", 32'(n_en), 32'd0);
        chk("s33_state", 32'(obs_state), 32'd3);
        chk("s33_done", 32'(obs_done), 32'd1);
        chk("s33_disp", 32'(obs_disp), 32'(to_bcd(119)));
        cyc(1, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("s33_start_ignored", 32'(obs_state), 32'd3);
        n_clr = 0;
        cyc(0, 0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        chk("s33_clr_count", 32'(n_clr), 32'd1);
        chk("s33_idle", 32'(obs_state), 32'd0);

        // clear beats start in PAUSE
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("s34_paused", 32'(obs_state), 32'd2);
        n_clr = 0; n_run = 0;
        cyc(1, 0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        chk("s34_clr_count", 32'(n_clr), 32'd1);
        chk("s34_no_run", 32'(n_run), 32'd0);
        chk("s34_idle", 32'(obs_state), 32'd0);

        // held start produces one edge
        n_pause = 0; n_run = 0;
        repeat (20) cyc(1, 0, 0, 0, 0);
        chk("s35_no_pause", 32'(n_pause), 32'd0);
        chk("s35_run_cycles", 32'(n_run), 32'd19);
        cyc(0, 0, 0, 0, 0);
        chk("s35_state", 32'(obs_state), 32'd1);

        // random traffic including mid-run resets
        s = 0; l = 0; c = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(5) == 0) s = !s;
            if ($urandom_range(5) == 0) l = !l;
            if ($urandom_range(9) == 0) c = !c;
            cyc(s, l, c, $urandom_range(3) != 0, $urandom_range(299) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter LIMIT_MIN, default 59, giving the minute value (0..59) of the terminal count LIMIT_MIN:59.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port tick, input, 1 bit: one-clk-cycle pulse per counted second.
REQ-005 The block SHALL have ports btnStart, btnLap and btnClear, each input, 1 bit: synchronized, debounced button levels.
REQ-006 The block SHALL have ports secUnits [3:0], secTens [2:0], minUnits [3:0] and minTens [2:0], all inputs: the live BCD count from the min:sec counter chain.
REQ-007 The block SHALL have port cntEn, output, 1 bit: count enable to the units-of-seconds counter.
REQ-008 The block SHALL have port cntClr, output, 1 bit: one-cycle synchronous clear request to the counter chain.
REQ-009 The block SHALL have ports dispSecUnits [3:0], dispSecTens [2:0], dispMinUnits [3:0] and dispMinTens [2:0], all outputs: the digits to display.
REQ-010 The block SHALL have port lapActive, output, 1 bit: display is frozen on a lap capture.
REQ-011 The block SHALL have port state, output, 2 bits: IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-012 The block SHALL have port done, output, 1 bit: high exactly while state==DONE.

Function
REQ-013 The block SHALL register btnStart, btnLap and btnClear each cycle and form startEdge, lapEdge and clrEdge as a 0->1 edge, i.e. level & ~previous level.
REQ-014 The block SHALL decode atLimit combinationally as minTens:minUnits == LIMIT_MIN and secTens:secUnits == 59.
REQ-015 The block SHALL drive cntEn combinationally as (state==RUN) & tick & ~atLimit, so the count is never enabled past LIMIT_MIN:59.
REQ-016 In IDLE the block SHALL go to RUN on startEdge, and on clrEdge it SHALL stay in IDLE and pulse cntClr.
REQ-017 In RUN the block SHALL go to DONE when atLimit is high; otherwise startEdge SHALL take it to PAUSE; clrEdge SHALL be ignored.
REQ-018 In PAUSE the block SHALL go to IDLE on clrEdge, pulsing cntClr and clearing lapActive; otherwise startEdge SHALL take it to RUN.
REQ-019 In DONE the block SHALL go to IDLE on clrEdge, pulsing cntClr and clearing lapActive; startEdge and lapEdge SHALL be ignored.
REQ-020 When several edges arrive in the same cycle, priority SHALL be atLimit (RUN only) > clrEdge > startEdge > lapEdge, and a lower-priority edge SHALL be discarded, not queued.
REQ-021 In RUN or PAUSE, lapEdge SHALL toggle lapActive; on a 0->1 toggle the live four digits SHALL be captured into the lap register in that same clock edge.
REQ-022 In IDLE, lapEdge SHALL have no effect.
REQ-023 The display outputs SHALL equal the lap register while lapActive=1, and the live count inputs otherwise (combinational select).
REQ-024 cntClr SHALL be a registered pulse asserted for exactly one cycle, in the cycle after the accepted clrEdge.
REQ-025 A button held high SHALL produce exactly one edge; the next edge requires a release.

Reset
REQ-026 While reset is high, the block SHALL asynchronously force: state=IDLE, cntClr=0, lapActive=0, lap register=0, previous button levels=0.
REQ-027 During reset, cntEn and done SHALL read 0.
REQ-028 The block SHALL accept the first edge no earlier than the first clk rising edge after reset deasserts; a button already high at reset release SHALL count as an edge.
REQ-029 Reset asserted mid-RUN SHALL stop counting immediately, because cntEn is forced low.

Verification
REQ-030 The bench SHALL cover this scenario: reset, startEdge, 10 ticks -> state=01, cntEn high on exactly 10 cycles, live count 00:10.
REQ-031 The bench SHALL cover this scenario: in RUN at 00:10, startEdge then 5 ticks -> state=10, cntEn never high; then clrEdge -> cntClr high for 1 cycle, state=00.
REQ-032 The bench SHALL cover this scenario: in RUN at 01:23, lapEdge, then 3 ticks -> disp shows 01:23 while live shows 01:26, lapActive=1; second lapEdge -> disp shows 01:26, lapActive=0.
REQ-033 The bench SHALL cover this scenario: LIMIT_MIN=1, run to 01:59 -> state=11 next cycle, done=1, further ticks give cntEn=0; startEdge ignored; clrEdge -> IDLE plus cntClr pulse.
REQ-034 The bench SHALL cover this scenario: in PAUSE, btnClear and btnStart rise in the same cycle -> state=00, cntClr pulse, no RUN entry.
REQ-035 The bench SHALL cover this scenario: btnStart held high for 20 cycles from IDLE -> single transition to RUN, no PAUSE.
